// File: rtl/gpio_arb_pkg.sv
// Shared types for the two-port APB4 GPIO arbiter: FSM states, the captured
// command record and the round-robin selection function.
package gpio_arb_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic                write;
      logic [DATA_W-1:0]   wdata;
      logic [DATA_W/8-1:0] strb;
   } apb_cmd_t;

   // A lone request is already one-hot; on a tie the port that was not served last wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) return last ? 2'b01 : 2'b10;
      return req;
   endfunction

endpackage

// File: rtl/gpio_arb_rr.sv
// Two-input round-robin picker; purely combinational, the pointer lives in the top.
module gpio_arb_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   import gpio_arb_pkg::*;

   assign gnt = rr_pick(req, last);

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Serialises two APB4 requesters onto one GPIO register slave, one atomic transfer at a time.
// Optional: define GPIO_APB_ARB_TIMEOUT_EN to abort downstream accesses stuck for TIMEOUT cycles.
module gpio_apb_arbiter #(
   parameter int GPIO_PINS = gpio_arb_pkg::DATA_W,
   parameter int ADDR_W    = gpio_arb_pkg::ADDR_W,
   parameter int TIMEOUT   = 16
) (
   input  logic                   pclk,
   input  logic                   prst,
   input  logic                   s0_psel,
   input  logic                   s0_penable,
   input  logic                   s0_pwrite,
   input  logic [ADDR_W-1:0]      s0_paddr,
   input  logic [GPIO_PINS-1:0]   s0_pwdata,
   input  logic [GPIO_PINS/8-1:0] s0_pstrb,
   output logic [GPIO_PINS-1:0]   s0_prdata,
   output logic                   s0_pready,
   output logic                   s0_pslverr,
   input  logic                   s1_psel,
   input  logic                   s1_penable,
   input  logic                   s1_pwrite,
   input  logic [ADDR_W-1:0]      s1_paddr,
   input  logic [GPIO_PINS-1:0]   s1_pwdata,
   input  logic [GPIO_PINS/8-1:0] s1_pstrb,
   output logic [GPIO_PINS-1:0]   s1_prdata,
   output logic                   s1_pready,
   output logic                   s1_pslverr,
   output logic                   m_psel,
   output logic                   m_penable,
   output logic                   m_pwrite,
   output logic [ADDR_W-1:0]      m_paddr,
   output logic [GPIO_PINS-1:0]   m_pwdata,
   output logic [GPIO_PINS/8-1:0] m_pstrb,
   input  logic [GPIO_PINS-1:0]   m_prdata,
   input  logic                   m_pready,
   input  logic                   m_pslverr,
   output logic [1:0]             grant
);
   import gpio_arb_pkg::*;

   arb_state_e           state;
   logic                 last;
   logic [1:0]           pick;
   apb_cmd_t             cmd;
   logic [GPIO_PINS-1:0] rsp_rdata;
   logic                 rsp_err;
   logic                 timeout_hit;
   logic                 drive;
   logic                 resp_done;

   gpio_arb_rr u_rr (
      .req  ({s1_psel, s0_psel}),
      .last (last),
      .gnt  (pick)
   );

`ifdef GPIO_APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Counts ACCESS cycles without pready; the TIMEOUT-th such cycle aborts.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge pclk) begin
      if (prst) begin
         wait_cnt <= '0;
      end else if (state == ARB_SETUP) begin
         wait_cnt <= '0;
      end else if (state == ARB_ACCESS && !m_pready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   assign resp_done = (grant[0] && s0_penable) || (grant[1] && s1_penable);

   // Control path: state, grant and round-robin pointer
   always_ff @(posedge pclk) begin
      if (prst) begin
         state <= ARB_IDLE;
         grant <= 2'b00;
         last  <= 1'b1;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|pick) begin
                  grant <= pick;
                  state <= ARB_SETUP;
               end
            end
            ARB_SETUP:  state <= ARB_ACCESS;
            ARB_ACCESS: if (m_pready || timeout_hit) state <= ARB_RESP;
            ARB_RESP: begin
               if (resp_done) begin
                  state <= ARB_IDLE;
                  grant <= 2'b00;
                  last  <= grant[1];
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Data path: command and response capture, never reset (outputs are gated by state)
   always_ff @(posedge pclk) begin
      if (state == ARB_IDLE) begin
         if (pick[1]) cmd <= '{addr: s1_paddr, write: s1_pwrite, wdata: s1_pwdata, strb: s1_pstrb};
         else         cmd <= '{addr: s0_paddr, write: s0_pwrite, wdata: s0_pwdata, strb: s0_pstrb};
      end
      if (state == ARB_ACCESS) begin
         if (m_pready) begin
            rsp_rdata <= m_prdata;
            rsp_err   <= m_pslverr;
         end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
         end
      end
   end

   assign drive     = (state == ARB_SETUP) || (state == ARB_ACCESS);
   assign m_psel    = drive;
   assign m_penable = (state == ARB_ACCESS);
   assign m_pwrite  = drive & cmd.write;
   assign m_paddr   = drive ? cmd.addr  : '0;
   assign m_pwdata  = drive ? cmd.wdata : '0;
   assign m_pstrb   = (drive && cmd.write) ? cmd.strb : '0;

   assign s0_pready  = (state == ARB_RESP) && grant[0] && s0_penable;
   assign s1_pready  = (state == ARB_RESP) && grant[1] && s1_penable;
   assign s0_prdata  = s0_pready ? rsp_rdata : '0;
   assign s1_prdata  = s1_pready ? rsp_rdata : '0;
   assign s0_pslverr = s0_pready & rsp_err;
   assign s1_pslverr = s1_pready & rsp_err;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter with response and downstream-command scoreboards.
module tb_gpio_apb_arbiter;

   logic        pclk = 1'b0;
   logic        prst;
   logic        s0_psel, s0_penable, s0_pwrite;
   logic [3:0]  s0_paddr;
   logic [31:0] s0_pwdata;
   logic [3:0]  s0_pstrb;
   logic [31:0] s0_prdata;
   logic        s0_pready, s0_pslverr;
   logic        s1_psel, s1_penable, s1_pwrite;
   logic [3:0]  s1_paddr;
   logic [31:0] s1_pwdata;
   logic [3:0]  s1_pstrb;
   logic [31:0] s1_prdata;
   logic        s1_pready, s1_pslverr;
   logic        m_psel, m_penable, m_pwrite;
   logic [3:0]  m_paddr;
   logic [31:0] m_pwdata;
   logic [3:0]  m_pstrb;
   logic [31:0] m_prdata;
   logic        m_pready, m_pslverr;
   logic [1:0]  grant;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [3:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   rsp_t q0[$];
   rsp_t q1[$];
   cmd_t qm[$];

   // Slave model: configurable wait states, response data, error and hang
   int          slv_wait  = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err   = 1'b0;
   logic        slv_hang  = 1'b0;
   int          wcnt      = 0;

   always @(posedge pclk) begin
      if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
      else                                  wcnt <= 0;
   end

   assign m_pready  = m_psel && m_penable && !slv_hang && (wcnt >= slv_wait);
   assign m_prdata  = m_pready ? slv_rdata : 32'h0;
   assign m_pslverr = m_pready & slv_err;

   gpio_apb_arbiter dut (
      .pclk       (pclk),
      .prst       (prst),
      .s0_psel    (s0_psel),
      .s0_penable (s0_penable),
      .s0_pwrite  (s0_pwrite),
      .s0_paddr   (s0_paddr),
      .s0_pwdata  (s0_pwdata),
      .s0_pstrb   (s0_pstrb),
      .s0_prdata  (s0_prdata),
      .s0_pready  (s0_pready),
      .s0_pslverr (s0_pslverr),
      .s1_psel    (s1_psel),
      .s1_penable (s1_penable),
      .s1_pwrite  (s1_pwrite),
      .s1_paddr   (s1_paddr),
      .s1_pwdata  (s1_pwdata),
      .s1_pstrb   (s1_pstrb),
      .s1_prdata  (s1_prdata),
      .s1_pready  (s1_pready),
      .s1_pslverr (s1_pslverr),
      .m_psel     (m_psel),
      .m_penable  (m_penable),
      .m_pwrite   (m_pwrite),
      .m_paddr    (m_paddr),
      .m_pwdata   (m_pwdata),
      .m_pstrb    (m_pstrb),
      .m_prdata   (m_prdata),
      .m_pready   (m_pready),
      .m_pslverr  (m_pslverr),
      .grant      (grant)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic port_ready(input int p);
      return (p == 0) ? s0_pready : s1_pready;
   endfunction

   task automatic drive(input int p, input logic sel, input logic en, input logic wr,
                        input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      if (p == 0) begin
         s0_psel = sel; s0_penable = en; s0_pwrite = wr; s0_paddr = a; s0_pwdata = d; s0_pstrb = s;
      end else begin
         s1_psel = sel; s1_penable = en; s1_pwrite = wr; s1_paddr = a; s1_pwdata = d; s1_pstrb = s;
      end
   endtask

   task automatic sync();
      @(posedge pclk);
      #1;
   endtask

   // One upstream APB4 transfer; lat counts cycles from psel rising to pready.
   task automatic xfer(input int p, input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int lat);
      drive(p, 1'b1, 1'b0, wr, a, d, s);
      sync();
      drive(p, 1'b1, 1'b1, wr, a, d, s);
      lat = 1;
      @(negedge pclk);
      while (!port_ready(p) && lat <= 60) begin
         lat++;
         @(negedge pclk);
      end
      chk($sformatf("p%0d_pready_within_bound", p), port_ready(p), 1'b1);
      sync();
      drive(p, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
   endtask

   // Upstream response scoreboard
   always @(negedge pclk) begin
      rsp_t e;
      if (s0_pready) begin
         chk("s0_pready_expected", q0.size() > 0, 1'b1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("s0_prdata", s0_prdata, e.rdata);
            chk("s0_pslverr", s0_pslverr, e.err);
         end
      end
      if (s1_pready) begin
         chk("s1_pready_expected", q1.size() > 0, 1'b1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("s1_prdata", s1_prdata, e.rdata);
            chk("s1_pslverr", s1_pslverr, e.err);
         end
      end
   end

   // Downstream command scoreboard, checked at each completed access
   always @(negedge pclk) begin
      cmd_t c;
      if (m_psel && m_penable && m_pready) begin
         chk("m_cmd_expected", qm.size() > 0, 1'b1);
         if (qm.size() > 0) begin
            c = qm.pop_front();
            chk("m_paddr", m_paddr, c.addr);
            chk("m_pwrite", m_pwrite, c.wr);
            chk("m_pwdata", m_pwdata, c.wdata);
            chk("m_pstrb", m_pstrb, c.strb);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat0, lat1;
      prst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      repeat (3) sync();

      // Reset state
      @(negedge pclk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_m_ctrl", {m_psel, m_penable, m_pwrite}, 3'b000);
      chk("rst_m_paddr", m_paddr, 4'h0);
      chk("rst_m_pwdata", m_pwdata, 32'h0);
      chk("rst_m_pstrb", m_pstrb, 4'h0);
      chk("rst_s_resp", {s0_pready, s0_pslverr, s1_pready, s1_pslverr}, 4'b0000);
      chk("rst_s_prdata", {s0_prdata, s1_prdata}, 64'h0);
      sync();
      prst = 1'b0;
      sync();

      // Tie straight after reset: port 0 first, then port 1
      slv_wait = 0; slv_rdata = 32'h0; slv_err = 1'b0;
      qm.push_back('{addr: 4'h1, wr: 1'b1, wdata: 32'h1111_1111, strb: 4'hF});
      qm.push_back('{addr: 4'h2, wr: 1'b1, wdata: 32'h2222_2222, strb: 4'h3});
      q0.push_back('{rdata: 32'h0, err: 1'b0});
      q1.push_back('{rdata: 32'h0, err: 1'b0});
      fork
         xfer(0, 1'b1, 4'h1, 32'h1111_1111, 4'hF, lat0);
         xfer(1, 1'b1, 4'h2, 32'h2222_2222, 4'h3, lat1);
      join
      chk("tie1_p0_latency", lat0, 3);
      chk("tie1_p1_latency", lat1, 7);
      sync();

      // Port 0 alone, zero-wait write, cycle-by-cycle view
      qm.push_back('{addr: 4'h4, wr: 1'b1, wdata: 32'hA5A5_0F0F, strb: 4'hF});
      q0.push_back('{rdata: 32'h0, err: 1'b0});
      fork
         xfer(0, 1'b1, 4'h4, 32'hA5A5_0F0F, 4'hF, lat0);
         begin
            @(negedge pclk);
            chk("w_c0_grant", grant, 2'b00);
            @(negedge pclk);
            chk("w_c1_grant", grant, 2'b01);
            chk("w_c1_setup", {m_psel, m_penable}, 2'b10);
            chk("w_c1_pwdata", m_pwdata, 32'hA5A5_0F0F);
            @(negedge pclk);
            chk("w_c2_access", {m_psel, m_penable}, 2'b11);
            chk("w_c2_pwdata", m_pwdata, 32'hA5A5_0F0F);
            @(negedge pclk);
            chk("w_c3_grant", grant, 2'b01);
            chk("w_c3_m_idle", {m_psel, m_penable}, 2'b00);
            @(negedge pclk);
            chk("w_c4_grant", grant, 2'b00);
         end
      join
      chk("w_latency", lat0, 3);
      sync();

      // Second tie after port 0 was last: port 1 wins
      slv_rdata = 32'h5A5A_0001;
      qm.push_back('{addr: 4'h3, wr: 1'b1, wdata: 32'h3333_0000, strb: 4'h1});
      qm.push_back('{addr: 4'h5, wr: 1'b1, wdata: 32'h0000_5555, strb: 4'h8});
      q0.push_back('{rdata: 32'h5A5A_0001, err: 1'b0});
      q1.push_back('{rdata: 32'h5A5A_0001, err: 1'b0});
      fork
         xfer(0, 1'b1, 4'h5, 32'h0000_5555, 4'h8, lat0);
         xfer(1, 1'b1, 4'h3, 32'h3333_0000, 4'h1, lat1);
      join
      chk("tie2_p1_latency", lat1, 3);
      chk("tie2_p0_latency", lat0, 7);
      sync();

      // Port 1 read with three wait states; strobes forced low on reads
      slv_wait = 3; slv_rdata = 32'h0000_00FF;
      qm.push_back('{addr: 4'h0, wr: 1'b0, wdata: 32'h0BAD_0000, strb: 4'h0});
      q1.push_back('{rdata: 32'h0000_00FF, err: 1'b0});
      xfer(1, 1'b0, 4'h0, 32'h0BAD_0000, 4'hF, lat1);
      chk("rd_wait_latency", lat1, 6);
      sync();

      // Slave error on a write
      slv_wait = 0; slv_rdata = 32'h0; slv_err = 1'b1;
      qm.push_back('{addr: 4'h6, wr: 1'b1, wdata: 32'hFEED_0006, strb: 4'hC});
      q0.push_back('{rdata: 32'h0, err: 1'b1});
      xfer(0, 1'b1, 4'h6, 32'hFEED_0006, 4'hC, lat0);
      chk("err_latency", lat0, 3);
      slv_err = 1'b0;
      sync();

      // Reset in ACCESS abandons the transfer
      slv_hang = 1'b1;
      drive(0, 1'b1, 1'b0, 1'b1, 4'h8, 32'h1234_5678, 4'h3);
      sync();
      drive(0, 1'b1, 1'b1, 1'b1, 4'h8, 32'h1234_5678, 4'h3);
      sync();
      @(negedge pclk);
      chk("prerst_access", {m_psel, m_penable}, 2'b11);
      chk("prerst_grant", grant, 2'b01);
      sync();
      prst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      sync();
      chk("midrst_grant", grant, 2'b00);
      chk("midrst_m_ctrl", {m_psel, m_penable, m_pwrite}, 3'b000);
      chk("midrst_m_data", {m_paddr, m_pwdata, m_pstrb}, 40'h0);
      chk("midrst_s_resp", {s0_pready, s1_pready}, 2'b00);
      prst = 1'b0;
      slv_hang = 1'b0;
      sync();

      slv_rdata = 32'hDEAD_BEEF;
      qm.push_back('{addr: 4'h9, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
      q1.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      xfer(1, 1'b0, 4'h9, 32'h0, 4'h0, lat1);
      chk("postrst_latency", lat1, 3);
      sync();

`ifdef GPIO_APB_ARB_TIMEOUT_EN
      // Slave never responds: abort after 16 ACCESS cycles
      slv_hang = 1'b1;
      q0.push_back('{rdata: 32'h0, err: 1'b1});
      xfer(0, 1'b0, 4'h7, 32'h0, 4'h0, lat0);
      chk("timeout_latency", lat0, 18);
      slv_hang = 1'b0;
      sync();
`endif

      repeat (2) sync();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("qm_drained", qm.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_apb_arbiter.md
# gpio_apb_arbiter

Two-port APB4 arbiter that shares one `lexicon_gpio` register slave between two independent APB4 requesters, for example the CPU bus and a DMA/boot sequencer. It accepts transactions on two upstream completer ports and serialises them onto one downstream requester port with round-robin fairness. Every transfer, including its response, is atomic: the grant is held until the response is returned. The block sits between the SoC APB fabric and the GPIO peripheral.

## Interface
- `GPIO_PINS`, 32, data width (PWDATA/PRDATA); strobe width is GPIO_PINS/8
- `ADDR_W`, 4, APB address width
- `TIMEOUT`, 16, downstream wait-cycle limit; used only with `GPIO_APB_ARB_TIMEOUT_EN`
- `pclk`  in  1  clock; all logic on rising edge
- `prst`  in  1  synchronous, active-high reset
- `s0_psel, s0_penable, s0_pwrite`  in  1 each  upstream port 0 APB4 control
- `s0_paddr`  in  ADDR_W  port 0 address
- `s0_pwdata`  in  GPIO_PINS  port 0 write data
- `s0_pstrb`  in  GPIO_PINS/8  port 0 byte strobes
- `s0_prdata`  out  GPIO_PINS  port 0 read data
- `s0_pready, s0_pslverr`  out  1 each  port 0 completion and error
- `s1_*`  same set as `s0_*`  upstream port 1
- `m_psel, m_penable, m_pwrite`  out  1 each  downstream control, to GPIO
- `m_paddr`  out  ADDR_W; `m_pwdata`  out  GPIO_PINS; `m_pstrb`  out  GPIO_PINS/8
- `m_prdata`  in  GPIO_PINS; `m_pready, m_pslverr`  in  1 each  downstream response
- `grant`  out  2  one-hot owner of the downstream port; 0 when idle

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: a request is `sN_psel=1`. Arbitration picks one requester and registers its paddr/pwrite/pwdata/pstrb into a command register. It sets `grant` and moves to SETUP.
- Round-robin: a pointer `last` records the last granted port. When both ports request in the same cycle, the port that is not `last` wins. A lone requester always wins. `last` resets to 1, so port 0 wins the first tie.
- SETUP: `m_psel=1`, `m_penable=0`. Unconditionally moves to ACCESS.
- ACCESS: `m_psel=1`, `m_penable=1`. Wait states are inserted while `m_pready=0`. On `m_pready=1`, register `m_prdata` and `m_pslverr`, deassert `m_psel`/`m_penable`, and move to RESP.
- RESP: assert granted `sN_pready=1` with the registered prdata/pslverr, but only when `sN_penable=1`. Then go to IDLE, clear `grant`, and update `last`.
- The non-granted port sees `pready=0` throughout and keeps its request pending. It is served in the next IDLE evaluation.
- `m_*` command outputs hold the command-register values from SETUP through ACCESS and are zero otherwise. `m_pstrb` is forced to 0 on reads.
- Reset values: all outputs 0, `grant=0`, state IDLE, `last=1`.
- Reset mid-transfer: the next edge forces IDLE and all outputs to 0. The abandoned transfer is never completed upstream.

## Timing
- Best-case latency from `sN_psel` rising (cycle 0) to `sN_pready`: cycle 0 arbitrate, cycle 1 SETUP, cycle 2 ACCESS (zero-wait slave), cycle 3 RESP. Total 3 cycles. Each downstream wait state adds 1 cycle.
- There is at least one IDLE cycle between consecutive downstream transfers.
- `sN_pready` is a single-cycle pulse.
- Upstream masters must hold address, data and control stable until they see pready (APB4 rule). The block samples these only in IDLE.

## Configuration
- `GPIO_APB_ARB_TIMEOUT_EN` defined: a cycle counter runs in ACCESS, cleared on SETUP entry. If `m_pready` is still 0 after TIMEOUT ACCESS cycles, the block aborts the transfer: it drops `m_psel`/`m_penable`, moves to RESP, and returns `pslverr=1`, `prdata=0`.
- Macro undefined: no counter, and ACCESS waits indefinitely for `m_pready`.

## Structure
- Package `gpio_arb_pkg`:
  - FSM state enum `arb_state_e`
  - packed struct `apb_cmd_t` (addr, write, wdata, strb)
  - `ADDR_W` default constant
- Sub-module `gpio_arb_rr`: 2-input round-robin picker. Inputs: requests and `last`. Output: one-hot grant. Combinational only; the pointer register lives in the top.

## Test plan
- Port 0 writes paddr=4'h4, pwdata=32'hA5A5_0F0F, pstrb=4'hF; slave has zero wait -> `m_pwdata` = A5A5_0F0F in SETUP/ACCESS; `s0_pready` in cycle 3; `grant`=01 then 00.
- Both ports request in the same cycle just after reset -> port 0 served first and port 1 next; a second tie is won by port 1 (alternation).
- Port 1 reads paddr=4'h0; slave inserts 3 wait states and returns 32'h0000_00FF -> `s1_prdata`=0000_00FF with `s1_pready` 6 cycles after the request; port 0 sees pready=0 throughout.
- Slave returns `m_pslverr=1` on a write -> `sN_pslverr=1` coincident with `sN_pready`.
- `prst` asserted while in ACCESS -> next edge all outputs 0 and `grant=0`; a new request afterwards completes normally.
- With `GPIO_APB_ARB_TIMEOUT_EN` and TIMEOUT=16, slave never asserts `m_pready` -> after 16 ACCESS cycles `pready=1`, `pslverr=1`, `prdata=0`.
